key_event_decoder: RTL and testbench
====================================

Name: key_event_decoder

Overview:
- Consumes the debounced, active-high key levels from the key stabilizer stage, one bit per key, 2 keys.
- Converts each level into one-cycle event pulses for the control logic: press, release, long-press and auto-repeat, plus a held level.
- Uses one shared millisecond prescaler and an independent FSM per key.

Parameters:
- CLK_FREQ_HZ, 50000000, sysClk frequency. Must be a multiple of 1000 and at least 2000.
- LONG_PRESS_MS, 1000, hold time in ms before keyLong fires. Range 1..65000.
- REPEAT_MS, 200, interval in ms between keyRepeat pulses after keyLong. Range 1..65000.

Ports:
- sysClk  input  1  system clock.
- sysRst  input  1  reset, asynchronous, active-low.
- stableKey  input  2  debounced key levels, 1 = pressed; may be asynchronous to sysClk.
- keyHeld  output  2  registered level, 1 while the key FSM is not IDLE.
- keyPress  output  2  one-cycle pulse on press.
- keyRelease  output  2  one-cycle pulse on release.
- keyLong  output  2  one-cycle pulse, once per press, when LONG_PRESS_MS is reached.
- keyRepeat  output  2  one-cycle pulse every REPEAT_MS after keyLong, while the key is held.

Behaviour:
- One clock, sysClk. Reset is asynchronous and active-low on sysRst.
- Reset values:
  - All outputs are 0.
  - Synchronizer and previous-value flops are 0.
  - Prescaler and hold counters are 0.
  - Both FSMs are IDLE.
- Input path, per bit: 2-flop synchronizer s1 -> s2, then edge register s3 <= s2.
  - rise = s2 & ~s3; fall = ~s2 & s3.
- ms tick: prescaler counts 0..CLK_FREQ_HZ/1000-1 and is free-running from reset release.
  - tick is high for one cycle when the count equals its maximum; the counter then wraps to 0.
  - First tick occurs CLK_FREQ_HZ/1000 cycles after reset release.
- Per-key FSM states: IDLE, PRESSED, LONG. All outputs are registered.
  - IDLE, rise: go to PRESSED, holdCnt <= 0, keyPress = 1 in the next cycle.
  - PRESSED, fall: go to IDLE, keyRelease = 1.
  - PRESSED, tick: holdCnt += 1. When the new value equals LONG_PRESS_MS: go to LONG, keyLong = 1, repCnt <= 0.
  - LONG, fall: go to IDLE, keyRelease = 1.
  - LONG, tick: repCnt += 1. When the new value equals REPEAT_MS: keyRepeat = 1, repCnt <= 0.
- Latency: keyPress and keyRelease assert exactly 3 sysClk edges after the first edge that samples the changed stableKey.
  - That is 2 synchronizer stages plus 1 output register.
- Long-press timing: keyLong fires between LONG_PRESS_MS-1 and LONG_PRESS_MS ms after PRESSED entry, because ticks are quantised.
  - Repeats are spaced exactly REPEAT_MS ms, i.e. REPEAT_MS*CLK_FREQ_HZ/1000 cycles.
- Counter widths:
  - holdCnt and repCnt are 16 bits unsigned and never wrap; the FSM leaves the state before the limit.
  - Prescaler width is clog2(CLK_FREQ_HZ/1000).
- Boundary conditions:
  - fall and the threshold tick in the same cycle: fall wins. Only keyRelease fires; no keyLong or keyRepeat.
  - rise while not IDLE cannot occur, because a fall must come first. Any rise in a non-IDLE state is ignored.
  - Press and release 1 cycle apart in stableKey: keyPress and keyRelease both fire, in consecutive cycles.
  - At most one of keyPress, keyRelease, keyLong, keyRepeat is high per key per cycle.
  - Keys are fully independent. Both keys can emit events in the same cycle. The tick is shared.
  - Reset mid-operation: all outputs drop to 0 immediately (asynchronous) and the FSM goes to IDLE.
  - If a key is still held at reset release, s3 = 0 makes a fresh rise, so a keyPress is emitted 3 cycles later and the long timing restarts.
- keyHeld equals (state != IDLE), registered, so it is aligned with keyPress and keyRelease.

Test Plan:
All scenarios use CLK_FREQ_HZ=4000 (4 cycles/ms), LONG_PRESS_MS=5, REPEAT_MS=2.
1. Reset check: assert sysRst=0 mid-stream with stableKey=2'b11 -> all outputs 0 at once. After release, keyPress=2'b11 pulses 3 cycles after the first sampling edge.
2. Short press: stableKey[0]=1 for 10 cycles -> keyPress[0] for 1 cycle at +3, keyHeld[0]=1 for 10 cycles, keyRelease[0] at +13, no keyLong.
3. Long hold: stableKey[0]=1 for 60 cycles -> keyLong[0] once, 16-20 cycles after keyPress. Then keyRepeat[0] exactly every 8 cycles until release, then keyRelease[0]; no repeat after release.
4. Race: release timed so fall coincides with the 5th tick -> keyRelease[0] only, keyLong[0] never asserts.
5. Independence: key0 long-held while key1 does 3 short presses -> key0 repeat spacing stays 8 cycles; 3 keyPress[1] and 3 keyRelease[1] pulses; no cross-talk.
6. Glitch pass-through: stableKey[1] high for 1 cycle -> keyPress[1] and keyRelease[1] in consecutive cycles, keyHeld[1] high for 1 cycle.

Source files
------------

// File: rtl/key_event_decoder.sv
// rtl/key_event_decoder.sv - debounced key levels to press/release/long/repeat pulses
// Two independent key FSMs share one free-running millisecond prescaler.
module key_event_decoder #(
  parameter int CLK_FREQ_HZ   = 50000000,
  parameter int LONG_PRESS_MS = 1000,
  parameter int REPEAT_MS     = 200
) (
  input  logic       sysClk,
  input  logic       sysRst,
  input  logic [1:0] stableKey,
  output logic [1:0] keyHeld,
  output logic [1:0] keyPress,
  output logic [1:0] keyRelease,
  output logic [1:0] keyLong,
  output logic [1:0] keyRepeat
);

  localparam int CYC_PER_MS = CLK_FREQ_HZ / 1000;
  localparam int PW         = (CYC_PER_MS > 1) ? $clog2(CYC_PER_MS) : 1;
  localparam logic [PW-1:0] PRE_MAX  = PW'(CYC_PER_MS - 1);
  localparam logic [15:0]   LONG_LIM = 16'(LONG_PRESS_MS);
  localparam logic [15:0]   REP_LIM  = 16'(REPEAT_MS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } state_t;

  logic [1:0]    s1_q, s2_q, s3_q;
  logic [1:0]    rise, fall;
  logic [PW-1:0] pre_q, pre_d;
  logic          tick;

  state_t        state_q [2];
  logic [15:0]   hold_q  [2];
  logic [15:0]   rep_q   [2];
  logic [1:0]    held_q, press_q, release_q, long_q, repeat_q;

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;
  assign tick = (pre_q == PRE_MAX);
  assign pre_d = tick ? '0 : pre_q + PW'(1);

  // s1/s2 resynchronise the asynchronous levels; s3 holds the previous value for edges
  always_ff @(posedge sysClk or negedge sysRst) begin
    if (!sysRst) begin
      s1_q  <= '0;
      s2_q  <= '0;
      s3_q  <= '0;
      pre_q <= '0;
    end else begin
      s1_q  <= stableKey;
      s2_q  <= s1_q;
      s3_q  <= s2_q;
      pre_q <= pre_d;
    end
  end

  always_ff @(posedge sysClk or negedge sysRst) begin
    if (!sysRst) begin
      for (int k = 0; k < 2; k++) begin
        state_q[k] <= ST_IDLE;
        hold_q[k]  <= '0;
        rep_q[k]   <= '0;
      end
      held_q    <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      repeat_q  <= '0;
    end else begin
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      repeat_q  <= '0;
      for (int k = 0; k < 2; k++) begin
        case (state_q[k])
          ST_IDLE: begin
            if (rise[k]) begin
              state_q[k] <= ST_PRESSED;
              hold_q[k]  <= '0;
              press_q[k] <= 1'b1;
              held_q[k]  <= 1'b1;
            end
          end
          // fall is tested first so a release on the threshold tick suppresses keyLong
          ST_PRESSED: begin
            if (fall[k]) begin
              state_q[k]   <= ST_IDLE;
              release_q[k] <= 1'b1;
              held_q[k]    <= 1'b0;
            end else if (tick) begin
              hold_q[k] <= hold_q[k] + 16'd1;
              if (hold_q[k] + 16'd1 == LONG_LIM) begin
                state_q[k] <= ST_LONG;
                long_q[k]  <= 1'b1;
                rep_q[k]   <= '0;
              end
            end
          end
          ST_LONG: begin
            if (fall[k]) begin
              state_q[k]   <= ST_IDLE;
              release_q[k] <= 1'b1;
              held_q[k]    <= 1'b0;
            end else if (tick) begin
              if (rep_q[k] + 16'd1 == REP_LIM) begin
                repeat_q[k] <= 1'b1;
                rep_q[k]    <= '0;
              end else begin
                rep_q[k] <= rep_q[k] + 16'd1;
              end
            end
          end
          default: begin
            state_q[k] <= ST_IDLE;
            held_q[k]  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign keyHeld    = held_q;
  assign keyPress   = press_q;
  assign keyRelease = release_q;
  assign keyLong    = long_q;
  assign keyRepeat  = repeat_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// tb/tb_key_event_decoder.sv - self-checking bench for key_event_decoder
// Model: outputs follow the input level delayed two edges; ticks land on every 4th edge.
module tb_key_event_decoder;

  logic       sysClk;
  logic       sysRst;
  logic [1:0] stableKey;
  logic [1:0] keyHeld, keyPress, keyRelease, keyLong, keyRepeat;

  key_event_decoder #(
    .CLK_FREQ_HZ  (4000),
    .LONG_PRESS_MS(5),
    .REPEAT_MS    (2)
  ) dut (
    .sysClk    (sysClk),
    .sysRst    (sysRst),
    .stableKey (stableKey),
    .keyHeld   (keyHeld),
    .keyPress  (keyPress),
    .keyRelease(keyRelease),
    .keyLong   (keyLong),
    .keyRepeat (keyRepeat)
  );

  initial sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  int total = 0;
  int bad   = 0;

  task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s at t=%0t: got %0d expected %0d..%0d", name, $time, act, lo, hi);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         n = 0;
  logic [1:0] hist [0:8191];
  int         ticks [2];
  logic [1:0] e_held, e_press, e_rel, e_long, e_rep;

  function automatic logic [1:0] lvl(input int i);
    if (i - 2 >= 1) return hist[i-2];
    return 2'b00;
  endfunction

  always @(posedge sysClk) begin
    logic [1:0] lc, lp;
    logic       tk;
    if (!sysRst) begin
      n = 0;
      e_held = '0; e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
      ticks[0] = 0; ticks[1] = 0;
    end else begin
      n++;
      if (n < 8192) hist[n] = stableKey;
      lc = lvl(n);
      lp = lvl(n - 1);
      tk = (n % 4 == 0);
      for (int k = 0; k < 2; k++) begin
        e_held[k]  = lc[k];
        e_press[k] = lc[k] & ~lp[k];
        e_rel[k]   = ~lc[k] & lp[k];
        e_long[k]  = 1'b0;
        e_rep[k]   = 1'b0;
        if (e_press[k]) ticks[k] = 0;
        else if (lc[k] && lp[k] && tk) begin
          ticks[k]++;
          if (ticks[k] == 5) e_long[k] = 1'b1;
          else if (ticks[k] > 5 && (ticks[k] - 5) % 2 == 0) e_rep[k] = 1'b1;
        end
      end
    end
  end

  // ---------------- compare + observation ----------------
  int press_cnt [2], rel_cnt [2], long_cnt [2], rep_cnt [2];
  int last_press [2], last_rel [2], last_long [2];
  int held1_cycles = 0;
  int rq0 [$];

  initial begin
    for (int k = 0; k < 2; k++) begin
      press_cnt[k] = 0; rel_cnt[k] = 0; long_cnt[k] = 0; rep_cnt[k] = 0;
      last_press[k] = -1; last_rel[k] = -1; last_long[k] = -1;
    end
  end

  always @(negedge sysClk) begin
    if (!sysRst) begin
      chk2("rst keyHeld", keyHeld, 2'b00);
      chk2("rst keyPress", keyPress, 2'b00);
      chk2("rst keyRelease", keyRelease, 2'b00);
      chk2("rst keyLong", keyLong, 2'b00);
      chk2("rst keyRepeat", keyRepeat, 2'b00);
    end else begin
      chk2("keyHeld", keyHeld, e_held);
      chk2("keyPress", keyPress, e_press);
      chk2("keyRelease", keyRelease, e_rel);
      chk2("keyLong", keyLong, e_long);
      chk2("keyRepeat", keyRepeat, e_rep);
      for (int k = 0; k < 2; k++) begin
        chk_int("one event per key", $countones({keyPress[k], keyRelease[k], keyLong[k], keyRepeat[k]}), 0, 1);
        if (keyPress[k])   begin press_cnt[k]++; last_press[k] = n; end
        if (keyRelease[k]) begin rel_cnt[k]++;   last_rel[k]   = n; end
        if (keyLong[k])    begin long_cnt[k]++;  last_long[k]  = n; end
        if (keyRepeat[k])  begin rep_cnt[k]++;   if (k == 0) rq0.push_back(n); end
      end
      if (keyHeld[1]) held1_cycles++;
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(posedge sysClk);
    #1;
  endtask

  function automatic int bad_gaps(input int first);
    int b = 0;
    int prev = first;
    foreach (rq0[i]) begin
      if (rq0[i] - prev != 8) b++;
      prev = rq0[i];
    end
    return b;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int d, p, t1, t5, f;
    int sp0, sr0, sl0, sq0, sp1, sr1, sl1, sq1, sh1;
    sysRst = 1'b0;
    stableKey = 2'b00;
    repeat (3) @(posedge sysClk);
    @(negedge sysClk) sysRst = 1'b1;

    // 1: reset mid-stream with both keys held
    cyc(1);
    stableKey = 2'b11;
    cyc(30);
    chk2("held before reset", keyHeld, 2'b11);
    #1 sysRst = 1'b0;
    #1 chk_int("async reset clears outputs",
               int'({keyHeld, keyPress, keyRelease, keyLong, keyRepeat}), 0, 0);
    repeat (2) @(negedge sysClk);
    sysRst = 1'b1;
    cyc(1); chk2("press after 1 edge", keyPress, 2'b00);
    cyc(1); chk2("press after 2 edges", keyPress, 2'b00);
    cyc(1); chk2("press after 3 edges", keyPress, 2'b11);
    cyc(1); chk2("press one cycle", keyPress, 2'b00);
    stableKey = 2'b00;
    cyc(20);

    // 2: short press on key 0
    sp0 = press_cnt[0]; sl0 = long_cnt[0];
    d = n;
    stableKey[0] = 1'b1;
    cyc(10);
    stableKey[0] = 1'b0;
    cyc(20);
    chk_int("short press count", press_cnt[0] - sp0, 1, 1);
    chk_int("short press latency", last_press[0] - d, 3, 3);
    chk_int("short release latency", last_rel[0] - d, 13, 13);
    chk_int("short no long", long_cnt[0] - sl0, 0, 0);

    // 3: long hold on key 0 for 60 cycles
    sl0 = long_cnt[0];
    rq0.delete();
    d = n;
    stableKey[0] = 1'b1;
    cyc(60);
    stableKey[0] = 1'b0;
    cyc(30);
    chk_int("long count", long_cnt[0] - sl0, 1, 1);
    chk_int("long after press", last_long[0] - last_press[0], 16, 20);
    chk_int("repeat count", rq0.size(), 4, 5);
    chk_int("repeat spacing", bad_gaps(last_long[0]), 0, 0);
    chk_int("long release latency", last_rel[0] - d, 63, 63);
    if (rq0.size() > 0) chk_int("no repeat after release", last_rel[0] - rq0[rq0.size()-1], 1, 8);

    // 4: release lands on the 5th tick
    sl0 = long_cnt[0]; sq0 = rep_cnt[0];
    d = n;
    stableKey[0] = 1'b1;
    p  = d + 3;
    t1 = (p / 4 + 1) * 4;
    t5 = t1 + 16;
    f  = t5 - 3;
    cyc(f - d);
    stableKey[0] = 1'b0;
    cyc(20);
    chk_int("race release edge", last_rel[0], t5, t5);
    chk_int("race no long", long_cnt[0] - sl0, 0, 0);
    chk_int("race no repeat", rep_cnt[0] - sq0, 0, 0);

    // 5: key 0 long-held while key 1 taps three times
    sp0 = press_cnt[0]; sr0 = rel_cnt[0]; sl0 = long_cnt[0];
    sp1 = press_cnt[1]; sr1 = rel_cnt[1]; sl1 = long_cnt[1]; sq1 = rep_cnt[1];
    rq0.delete();
    stableKey[0] = 1'b1;
    cyc(22);
    for (int i = 0; i < 3; i++) begin
      stableKey[1] = 1'b1;
      cyc(4);
      stableKey[1] = 1'b0;
      cyc(4);
    end
    cyc(30);
    stableKey[0] = 1'b0;
    cyc(20);
    chk_int("indep key1 presses", press_cnt[1] - sp1, 3, 3);
    chk_int("indep key1 releases", rel_cnt[1] - sr1, 3, 3);
    chk_int("indep key1 no long/repeat", (long_cnt[1] - sl1) + (rep_cnt[1] - sq1), 0, 0);
    chk_int("indep key0 press/release", (press_cnt[0] - sp0) + (rel_cnt[0] - sr0), 2, 2);
    chk_int("indep key0 long", long_cnt[0] - sl0, 1, 1);
    chk_int("indep key0 repeat count", rq0.size(), 6, 7);
    chk_int("indep key0 repeat spacing", bad_gaps(last_long[0]), 0, 0);

    // 6: one-cycle glitch on key 1
    sp0 = press_cnt[0]; sh1 = held1_cycles;
    d = n;
    stableKey[1] = 1'b1;
    cyc(1);
    stableKey[1] = 1'b0;
    cyc(10);
    chk_int("glitch press edge", last_press[1] - d, 3, 3);
    chk_int("glitch release edge", last_rel[1] - d, 4, 4);
    chk_int("glitch held cycles", held1_cycles - sh1, 1, 1);
    chk_int("glitch no key0 crosstalk", press_cnt[0] - sp0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
